// File: rtl/alu2_cdb_result_broadcaster.sv
// ALU2 result FIFO feeding the ALU2 channel of the common data bus.
// Results queue in acceptance order and leave one per CDB grant through a registered broadcast stage.
module alu2_cdb_result_broadcaster #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iFLUSH,
  input  logic        iEXEC_VALID,
  input  logic        iEXEC_WRITEBACK,
  input  logic        iEXEC_DESTINATION_SYSREG,
  input  logic [5:0]  iEXEC_DESTINATION_REGNAME,
  input  logic [5:0]  iEXEC_COMMIT_TAG,
  input  logic [31:0] iEXEC_DATA,
  output logic        oEXEC_LOCK,
  output logic        oCDB_REQ,
  input  logic        iCDB_GRANT,
  output logic        oCDB_VALID,
  output logic        oCDB_WRITEBACK,
  output logic        oCDB_DESTINATION_SYSREG,
  output logic [5:0]  oCDB_DESTINATION_REGNAME,
  output logic [5:0]  oCDB_COMMIT_TAG,
  output logic [31:0] oCDB_DATA,
  output logic        oOVERFLOW
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic        wb;
    logic        sysreg;
    logic [5:0]  regname;
    logic [5:0]  tag;
    logic [31:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             out_q;
  entry_t             wr_entry;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               valid_q;
  logic               overflow_q;
  logic               push;
  logic               pop;

  assign oEXEC_LOCK = (count == CNT_W'(DEPTH));
  assign oCDB_REQ   = (count != '0);

  // Flush outranks both queue operations.
  assign push = iEXEC_VALID && !oEXEC_LOCK && !iFLUSH;
  assign pop  = oCDB_REQ && iCDB_GRANT && !iFLUSH;

  assign wr_entry = '{wb:      iEXEC_WRITEBACK,
                      sysreg:  iEXEC_DESTINATION_SYSREG,
                      regname: iEXEC_DESTINATION_REGNAME,
                      tag:     iEXEC_COMMIT_TAG,
                      data:    iEXEC_DATA};

  // Storage array; occupancy is tracked separately so no reset is needed here.
  always_ff @(posedge iCLOCK) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid_q    <= 1'b0;
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Sticky: a dropped push stays visible even across flushes.
      if (iEXEC_VALID && oEXEC_LOCK) begin
        overflow_q <= 1'b1;
      end
      if (iFLUSH) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= pop;
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          out_q  <= mem[rd_ptr];
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  assign oCDB_VALID               = valid_q;
  assign oCDB_WRITEBACK           = out_q.wb;
  assign oCDB_DESTINATION_SYSREG  = out_q.sysreg;
  assign oCDB_DESTINATION_REGNAME = out_q.regname;
  assign oCDB_COMMIT_TAG          = out_q.tag;
  assign oCDB_DATA                = out_q.data;
  assign oOVERFLOW                = overflow_q;

endmodule

// File: tb/tb_alu2_cdb_result_broadcaster.sv
// Directed bench for alu2_cdb_result_broadcaster; checks broadcasts, backpressure, flush and reset.
module tb_alu2_cdb_result_broadcaster;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iFLUSH;
  logic        iEXEC_VALID;
  logic        iEXEC_WRITEBACK;
  logic        iEXEC_DESTINATION_SYSREG;
  logic [5:0]  iEXEC_DESTINATION_REGNAME;
  logic [5:0]  iEXEC_COMMIT_TAG;
  logic [31:0] iEXEC_DATA;
  logic        oEXEC_LOCK;
  logic        oCDB_REQ;
  logic        iCDB_GRANT;
  logic        oCDB_VALID;
  logic        oCDB_WRITEBACK;
  logic        oCDB_DESTINATION_SYSREG;
  logic [5:0]  oCDB_DESTINATION_REGNAME;
  logic [5:0]  oCDB_COMMIT_TAG;
  logic [31:0] oCDB_DATA;
  logic        oOVERFLOW;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  alu2_cdb_result_broadcaster #(.DEPTH(4), .PTR_W(2)) dut (
    .iCLOCK                    (iCLOCK),
    .inRESET                   (inRESET),
    .iFLUSH                    (iFLUSH),
    .iEXEC_VALID               (iEXEC_VALID),
    .iEXEC_WRITEBACK           (iEXEC_WRITEBACK),
    .iEXEC_DESTINATION_SYSREG  (iEXEC_DESTINATION_SYSREG),
    .iEXEC_DESTINATION_REGNAME (iEXEC_DESTINATION_REGNAME),
    .iEXEC_COMMIT_TAG          (iEXEC_COMMIT_TAG),
    .iEXEC_DATA                (iEXEC_DATA),
    .oEXEC_LOCK                (oEXEC_LOCK),
    .oCDB_REQ                  (oCDB_REQ),
    .iCDB_GRANT                (iCDB_GRANT),
    .oCDB_VALID                (oCDB_VALID),
    .oCDB_WRITEBACK            (oCDB_WRITEBACK),
    .oCDB_DESTINATION_SYSREG   (oCDB_DESTINATION_SYSREG),
    .oCDB_DESTINATION_REGNAME  (oCDB_DESTINATION_REGNAME),
    .oCDB_COMMIT_TAG           (oCDB_COMMIT_TAG),
    .oCDB_DATA                 (oCDB_DATA),
    .oOVERFLOW                 (oOVERFLOW)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then back to the falling edge where outputs are sampled and inputs driven.
  task automatic step();
    @(posedge iCLOCK);
    @(negedge iCLOCK);
  endtask

  task automatic drive_push(input logic wb, input logic sys, input logic [5:0] rn,
                            input logic [5:0] tg, input logic [31:0] d);
    iEXEC_VALID               = 1'b1;
    iEXEC_WRITEBACK           = wb;
    iEXEC_DESTINATION_SYSREG  = sys;
    iEXEC_DESTINATION_REGNAME = rn;
    iEXEC_COMMIT_TAG          = tg;
    iEXEC_DATA                = d;
  endtask

  task automatic chk_bc(input string tag, input logic wb, input logic sys, input logic [5:0] rn,
                        input logic [5:0] tg, input logic [31:0] d);
    chk({tag, ".valid"},   32'(oCDB_VALID), 32'd1);
    chk({tag, ".wb"},      32'(oCDB_WRITEBACK), 32'(wb));
    chk({tag, ".sysreg"},  32'(oCDB_DESTINATION_SYSREG), 32'(sys));
    chk({tag, ".regname"}, 32'(oCDB_DESTINATION_REGNAME), 32'(rn));
    chk({tag, ".tag"},     32'(oCDB_COMMIT_TAG), 32'(tg));
    chk({tag, ".data"},    oCDB_DATA, d);
  endtask

  initial begin
    int pushed;
    int seen;
    logic [31:0] nxt;
    logic [31:0] head;

    inRESET = 1'b0; iFLUSH = 1'b0; iEXEC_VALID = 1'b0; iEXEC_WRITEBACK = 1'b0;
    iEXEC_DESTINATION_SYSREG = 1'b0; iEXEC_DESTINATION_REGNAME = '0;
    iEXEC_COMMIT_TAG = '0; iEXEC_DATA = '0; iCDB_GRANT = 1'b0;
    #1;
    chk("rst.valid", 32'(oCDB_VALID), 32'd0);
    chk("rst.req", 32'(oCDB_REQ), 32'd0);
    chk("rst.lock", 32'(oEXEC_LOCK), 32'd0);
    chk("rst.ovf", 32'(oOVERFLOW), 32'd0);
    chk("rst.data", oCDB_DATA, 32'd0);
    @(negedge iCLOCK);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    @(negedge iCLOCK);

    // Single result with grant held high
    drive_push(1'b1, 1'b0, 6'h05, 6'h01, 32'hDEADBEEF);
    iCDB_GRANT = 1'b1;
    step();
    iEXEC_VALID = 1'b0;
    chk("single.req", 32'(oCDB_REQ), 32'd1);
    chk("single.valid_early", 32'(oCDB_VALID), 32'd0);
    step();
    chk_bc("single", 1'b1, 1'b0, 6'h05, 6'h01, 32'hDEADBEEF);
    chk("single.req_after", 32'(oCDB_REQ), 32'd0);
    step();
    chk("single.valid_pulse", 32'(oCDB_VALID), 32'd0);

    // Backpressure: five pushes with no grant, the fifth must be dropped
    iCDB_GRANT = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_push(1'b1, i[0], 6'(i), 6'(i + 8), 32'h100 + 32'(i));
      step();
      if (i == 3) begin
        chk("bp.lock4", 32'(oEXEC_LOCK), 32'd1);
        chk("bp.ovf_before", 32'(oOVERFLOW), 32'd0);
      end
    end
    iEXEC_VALID = 1'b0;
    chk("bp.ovf", 32'(oOVERFLOW), 32'd1);
    chk("bp.lock5", 32'(oEXEC_LOCK), 32'd1);
    iCDB_GRANT = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_bc("bp.drain", 1'b1, i[0], 6'(i), 6'(i + 8), 32'h100 + 32'(i));
    end
    chk("bp.req_empty", 32'(oCDB_REQ), 32'd0);
    step();
    chk("bp.no_fifth", 32'(oCDB_VALID), 32'd0);

    // Concurrent push/pop across pointer wrap, producer honours LOCK
    iCDB_GRANT = 1'b0;
    nxt = 32'h200;
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b1, 1'b0, 6'h10, 6'h20, nxt);
      exp_q.push_back(nxt);
      nxt++;
      step();
    end
    iEXEC_VALID = 1'b0;
    chk("conc.full", 32'(oEXEC_LOCK), 32'd1);
    pushed = 0;
    seen = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (oCDB_VALID) begin
        seen++;
        head = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk("conc.order", oCDB_DATA, head);
      end
      iCDB_GRANT = 1'b1;
      if (!oEXEC_LOCK && pushed < 10) begin
        drive_push(1'b1, 1'b0, 6'h10, 6'h20, nxt);
        exp_q.push_back(nxt);
        nxt++;
        pushed++;
      end else begin
        iEXEC_VALID = 1'b0;
      end
      step();
    end
    iEXEC_VALID = 1'b0;
    chk("conc.pushed", 32'(pushed), 32'd10);
    chk("conc.seen", 32'(seen), 32'd14);
    chk("conc.leftover", 32'(exp_q.size()), 32'd0);

    // Flush with three held entries plus a same-cycle push and grant
    iCDB_GRANT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 1'b0, 6'h01, 6'h02, 32'h300 + 32'(i));
      step();
    end
    chk("flush.held_req", 32'(oCDB_REQ), 32'd1);
    iFLUSH = 1'b1;
    iCDB_GRANT = 1'b1;
    drive_push(1'b1, 1'b0, 6'h01, 6'h02, 32'h3FF);
    step();
    iFLUSH = 1'b0;
    iEXEC_VALID = 1'b0;
    chk("flush.req", 32'(oCDB_REQ), 32'd0);
    chk("flush.valid", 32'(oCDB_VALID), 32'd0);
    step();
    chk("flush.valid_late", 32'(oCDB_VALID), 32'd0);
    chk("flush.req_late", 32'(oCDB_REQ), 32'd0);
    chk("flush.ovf_sticky", 32'(oOVERFLOW), 32'd1);

    // Reset while a broadcast is in flight and two entries remain
    iCDB_GRANT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 1'b1, 6'h02, 6'h03, 32'h400 + 32'(i));
      step();
    end
    iEXEC_VALID = 1'b0;
    iCDB_GRANT = 1'b1;
    step();
    chk_bc("rstmid.pre", 1'b1, 1'b1, 6'h02, 6'h03, 32'h400);
    chk("rstmid.pre_req", 32'(oCDB_REQ), 32'd1);
    iCDB_GRANT = 1'b0;
    inRESET = 1'b0;
    #1;
    chk("rstmid.valid", 32'(oCDB_VALID), 32'd0);
    chk("rstmid.req", 32'(oCDB_REQ), 32'd0);
    chk("rstmid.ovf", 32'(oOVERFLOW), 32'd0);
    chk("rstmid.data", oCDB_DATA, 32'd0);
    chk("rstmid.sysreg", 32'(oCDB_DESTINATION_SYSREG), 32'd0);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    @(negedge iCLOCK);
    drive_push(1'b1, 1'b0, 6'h09, 6'h03, 32'h500);
    iCDB_GRANT = 1'b1;
    step();
    iEXEC_VALID = 1'b0;
    chk("rstmid.post_req", 32'(oCDB_REQ), 32'd1);
    step();
    chk_bc("rstmid.post", 1'b1, 1'b0, 6'h09, 6'h03, 32'h500);

    // Result that does not write a register still broadcasts its commit tag
    drive_push(1'b0, 1'b0, 6'h11, 6'h2A, 32'h600);
    step();
    iEXEC_VALID = 1'b0;
    step();
    chk_bc("nowb", 1'b0, 1'b0, 6'h11, 6'h2A, 32'h600);
    step();
    chk("nowb.pulse", 32'(oCDB_VALID), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
